// File: rtl/hub75_ram_rd_arbiter_pkg.sv
// Shared definitions for the HUB75 main-RAM read arbiter: RAM geometry,
// requester ownership encoding and the in-flight read tag.
package hub75_ram_rd_arbiter_pkg;

    localparam int RAM_AW = 15;
    localparam int RAM_DW = 20;
    localparam int FB_AW  = 14;

    localparam logic [RAM_AW-1:0] NP_BASE_DEF = 15'h4000;

    typedef enum logic {
        OWN_P = 1'b0,
        OWN_N = 1'b1
    } owner_e;

    typedef struct packed {
        logic   valid;
        owner_e owner;
    } rd_tag_t;

    // Neopixel region lives at a fixed offset; the caller passes a zero-extended local address.
    function automatic logic [RAM_AW-1:0] np_map(input logic [RAM_AW-1:0] base,
                                                 input logic [RAM_AW-1:0] offs);
        return base + offs;
    endfunction

endpackage

// File: rtl/hub75_rd_tag_pipe.sv
// Fixed-depth shift register carrying {valid, owner} for each RAM read so the
// returning data can be steered back to the requester that issued it.
module hub75_rd_tag_pipe
    import hub75_ram_rd_arbiter_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic    i_clk,
    input  logic    i_rst,
    input  rd_tag_t i_tag,
    output rd_tag_t o_tag
);

    rd_tag_t r_pipe [RD_LAT];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            // NOTE: this storage is reset because its valid bits gate the outputs; pure data storage would not need a reset.
            for (int i = 0; i < RD_LAT; i++) begin
                r_pipe[i] <= '0;
            end
        end else begin
            r_pipe[0] <= i_tag;
            for (int i = 1; i < RD_LAT; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign o_tag = r_pipe[RD_LAT-1];

endmodule

// File: rtl/hub75_ram_rd_arbiter.sv
// Shares the single main-RAM read port between the panel fetch path (P, priority)
// and the neopixel path (N, guaranteed a slot by a starvation counter).
module hub75_ram_rd_arbiter
    import hub75_ram_rd_arbiter_pkg::*;
#(
    parameter int                RD_LAT   = 1,
    parameter int                MAX_WAIT = 8,
    parameter logic [RAM_AW-1:0] NP_BASE  = NP_BASE_DEF,
    parameter int                NP_AW    = 10
) (
    input  logic              sys_clk,
    input  logic              rst,
    input  logic              p_req,
    input  logic [FB_AW-1:0]  p_addr,
    output logic              p_gnt,
    output logic              p_rvalid,
    output logic [RAM_DW-1:0] p_rdata,
    input  logic              n_req,
    input  logic [NP_AW-1:0]  n_addr,
    output logic              n_gnt,
    output logic              n_rvalid,
    output logic [RAM_DW-1:0] n_rdata,
    output logic [RAM_AW-1:0] ram_raddr,
    output logic              ram_re,
    input  logic [RAM_DW-1:0] ram_rdata,
    output logic              n_starved
);

    localparam logic [7:0] WAIT_LIM = 8'(MAX_WAIT - 1);

    logic [7:0]        r_wait_cnt;
    logic [RAM_AW-1:0] r_raddr_last;
    logic              r_n_starved;
    logic              r_p_rvalid;
    logic              r_n_rvalid;
    logic [RAM_DW-1:0] r_p_rdata;
    logic [RAM_DW-1:0] r_n_rdata;

    logic              w_force_n;
    logic              w_gnt_p;
    logic              w_gnt_n;
    logic [RAM_AW-1:0] w_n_raddr;
    logic [RAM_AW-1:0] w_raddr;
    rd_tag_t           w_tag_in;
    rd_tag_t           w_tag_out;

    assign w_n_raddr = np_map(NP_BASE, RAM_AW'(n_addr));

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path leaves one unassigned and infers a latch.
        w_force_n = p_req && n_req && (r_wait_cnt == WAIT_LIM);
        w_gnt_n   = 1'b0;
        w_gnt_p   = 1'b0;
        w_raddr   = r_raddr_last;
        w_tag_in  = '0;
        if (!rst) begin
            w_gnt_n = n_req && (!p_req || w_force_n);
            w_gnt_p = p_req && !w_gnt_n;
        end
        if (w_gnt_p) begin
            w_raddr = {1'b0, p_addr};
        end else if (w_gnt_n) begin
            w_raddr = w_n_raddr;
        end
        w_tag_in.valid = w_gnt_p || w_gnt_n;
        w_tag_in.owner = w_gnt_n ? OWN_N : OWN_P;
    end

    hub75_rd_tag_pipe #(
        .RD_LAT (RD_LAT)
    ) u_tag_pipe (
        .i_clk (sys_clk),
        .i_rst (rst),
        .i_tag (w_tag_in),
        .o_tag (w_tag_out)
    );

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            r_wait_cnt   <= '0;
            r_raddr_last <= '0;
            r_n_starved  <= 1'b0;
            r_p_rvalid   <= 1'b0;
            r_n_rvalid   <= 1'b0;
            r_p_rdata    <= '0;
            r_n_rdata    <= '0;
        end else begin
            // NOTE: state uses <= only, so every statement here sees the pre-edge values regardless of order.
            if (w_tag_in.valid) begin
                r_raddr_last <= w_raddr;
            end

            if (!n_req || w_gnt_n) begin
                r_wait_cnt <= '0;
            end else if (w_gnt_p && (r_wait_cnt != WAIT_LIM)) begin
                r_wait_cnt <= r_wait_cnt + 8'd1;
            end

            if (w_gnt_n && w_force_n) begin
                r_n_starved <= 1'b1;
            end

            // Exiting tag steers this cycle's RAM data; the other requester's data holds.
            r_p_rvalid <= w_tag_out.valid && (w_tag_out.owner == OWN_P);
            r_n_rvalid <= w_tag_out.valid && (w_tag_out.owner == OWN_N);
            if (w_tag_out.valid && (w_tag_out.owner == OWN_P)) begin
                r_p_rdata <= ram_rdata;
            end
            if (w_tag_out.valid && (w_tag_out.owner == OWN_N)) begin
                r_n_rdata <= ram_rdata;
            end
        end
    end

    assign p_gnt     = w_gnt_p;
    assign n_gnt     = w_gnt_n;
    assign ram_re    = w_tag_in.valid;
    assign ram_raddr = w_raddr;
    assign p_rvalid  = r_p_rvalid;
    assign n_rvalid  = r_n_rvalid;
    assign p_rdata   = r_p_rdata;
    assign n_rdata   = r_n_rdata;
    assign n_starved = r_n_starved;

endmodule

// File: tb/tb_hub75_ram_rd_arbiter.sv
// Bench for hub75_ram_rd_arbiter: a behavioural RAM, a grant model and a
// scoreboard of expected read returns checked as the DUT produces them.
module tb_hub75_ram_rd_arbiter;
    import hub75_ram_rd_arbiter_pkg::*;

    localparam int          RD_LAT   = 2;
    localparam int          MAX_WAIT = 8;
    localparam int          NP_AW    = 10;
    localparam logic [14:0] NPB      = 15'h4000;

    logic        sys_clk = 1'b0;
    logic        rst     = 1'b1;
    logic        p_req   = 1'b0;
    logic [13:0] p_addr  = '0;
    logic        p_gnt;
    logic        p_rvalid;
    logic [19:0] p_rdata;
    logic        n_req   = 1'b0;
    logic [9:0]  n_addr  = '0;
    logic        n_gnt;
    logic        n_rvalid;
    logic [19:0] n_rdata;
    logic [14:0] ram_raddr;
    logic        ram_re;
    logic [19:0] ram_rdata;
    logic        n_starved;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    hub75_ram_rd_arbiter #(
        .RD_LAT   (RD_LAT),
        .MAX_WAIT (MAX_WAIT),
        .NP_BASE  (NPB),
        .NP_AW    (NP_AW)
    ) dut (
        .sys_clk   (sys_clk),
        .rst       (rst),
        .p_req     (p_req),
        .p_addr    (p_addr),
        .p_gnt     (p_gnt),
        .p_rvalid  (p_rvalid),
        .p_rdata   (p_rdata),
        .n_req     (n_req),
        .n_addr    (n_addr),
        .n_gnt     (n_gnt),
        .n_rvalid  (n_rvalid),
        .n_rdata   (n_rdata),
        .ram_raddr (ram_raddr),
        .ram_re    (ram_re),
        .ram_rdata (ram_rdata),
        .n_starved (n_starved)
    );

    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc <= cyc + 1;

    // Content is a fixed function of the address; 15'h1234 holds 20'hABCDE.
    function automatic logic [19:0] ram_f(input logic [14:0] a);
        return 20'hABCDE ^ 20'(a) ^ 20'h01234;
    endfunction

    logic [14:0] m_ra [RD_LAT];
    always @(posedge sys_clk) begin
        m_ra[0] <= ram_raddr;
        for (int i = 1; i < RD_LAT; i++) m_ra[i] <= m_ra[i-1];
    end
    assign ram_rdata = ram_f(m_ra[RD_LAT-1]);

    typedef struct {
        owner_e      owner;
        logic [19:0] data;
        int          due;
    } exp_t;
    exp_t sb[$];

    int          m_wait    = 0;
    logic        m_starved = 1'b0;
    logic [14:0] m_last    = '0;
    logic        e_p, e_n, e_force, e_starved;
    logic [14:0] e_addr;

    bit          mon_en = 1'b0;
    logic [19:0] m_prd  = '0;
    logic [19:0] m_nrd  = '0;

    // Drives one cycle of requests and predicts the grant, pushing the expected return.
    task automatic drive(input logic p, input logic [13:0] pa, input logic n, input logic [9:0] na);
        p_req = p; p_addr = pa; n_req = n; n_addr = na;
        @(negedge sys_clk);
        e_force   = p && n && (m_wait == MAX_WAIT - 1);
        e_n       = n && (!p || e_force);
        e_p       = p && !e_n;
        e_starved = m_starved;
        if (e_p)      e_addr = {1'b0, pa};
        else if (e_n) e_addr = NPB + 15'(na);
        else          e_addr = m_last;
        if (e_p || e_n) begin
            m_last = e_addr;
            sb.push_back('{owner: (e_n ? OWN_N : OWN_P), data: ram_f(e_addr), due: cyc + RD_LAT + 1});
        end
        if (!n || e_n)                        m_wait = 0;
        else if (e_p && m_wait < MAX_WAIT - 1) m_wait++;
        if (e_n && e_force) m_starved = 1'b1;
    endtask

    task automatic advance();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            drive(1'b0, '0, 1'b0, '0);
            advance();
        end
    endtask

    task automatic model_reset();
        sb.delete();
        m_wait = 0; m_starved = 1'b0; m_last = '0;
        m_prd = '0; m_nrd = '0;
    endtask

    always @(negedge sys_clk) begin
        if (mon_en && !rst) begin
            exp_t e;
            logic xp, xn;
            xp = 1'b0; xn = 1'b0;
            if (sb.size() != 0 && sb[0].due == cyc) begin
                e = sb.pop_front();
                if (e.owner == OWN_P) begin xp = 1'b1; m_prd = e.data; end
                else                  begin xn = 1'b1; m_nrd = e.data; end
            end
            vectors++;
            if ({p_rvalid, n_rvalid} !== {xp, xn}) begin
                miscompares++;
                $display("FAIL rvalid cyc=%0d: got p=%b n=%b, want p=%b n=%b", cyc, p_rvalid, n_rvalid, xp, xn);
            end
            vectors++;
            if (p_rdata !== m_prd) begin
                miscompares++;
                $display("FAIL p_rdata cyc=%0d: got %h, want %h", cyc, p_rdata, m_prd);
            end
            vectors++;
            if (n_rdata !== m_nrd) begin
                miscompares++;
                $display("FAIL n_rdata cyc=%0d: got %h, want %h", cyc, n_rdata, m_nrd);
            end
        end
    end

    task automatic test_reset();
        rst = 1'b1; p_req = 1'b1; n_req = 1'b1; p_addr = '0; n_addr = '0;
        repeat (2) @(posedge sys_clk);
        @(negedge sys_clk);
        vectors++;
        if ({p_gnt, n_gnt, ram_re, p_rvalid, n_rvalid, n_starved} !== 6'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl: got gp=%b gn=%b re=%b pv=%b nv=%b st=%b, want all 0",
                     p_gnt, n_gnt, ram_re, p_rvalid, n_rvalid, n_starved);
        end
        vectors++;
        if ({ram_raddr, p_rdata, n_rdata} !== '0) begin
            miscompares++;
            $display("FAIL reset_data: got raddr=%h prd=%h nrd=%h, want 0", ram_raddr, p_rdata, n_rdata);
        end
        @(posedge sys_clk);
        #1;
        rst = 1'b0;
        model_reset();
        mon_en = 1'b1;
        drive(1'b1, 14'h0000, 1'b1, 10'h000);
        vectors++;
        if ({p_gnt, n_gnt, ram_re, ram_raddr} !== {1'b1, 1'b0, 1'b1, 15'h0000}) begin
            miscompares++;
            $display("FAIL first_grant: got gp=%b gn=%b re=%b raddr=%h, want 1 0 1 0000", p_gnt, n_gnt, ram_re, ram_raddr);
        end
        advance();
        idle(RD_LAT + 2);
    endtask

    task automatic test_p_only();
        drive(1'b1, 14'h1234, 1'b0, 10'h000);
        vectors++;
        if ({p_gnt, n_gnt, ram_re, ram_raddr} !== {1'b1, 1'b0, 1'b1, 15'h1234}) begin
            miscompares++;
            $display("FAIL p_only_grant: got gp=%b gn=%b re=%b raddr=%h, want 1 0 1 1234", p_gnt, n_gnt, ram_re, ram_raddr);
        end
        advance();
        drive(1'b0, 14'h3FFF, 1'b0, 10'h3FF);
        vectors++;
        if ({ram_re, ram_raddr} !== {1'b0, 15'h1234}) begin
            miscompares++;
            $display("FAIL idle_hold: got re=%b raddr=%h, want 0 1234", ram_re, ram_raddr);
        end
        advance();
        idle(RD_LAT + 1);
        vectors++;
        if (p_rdata !== 20'hABCDE) begin
            miscompares++;
            $display("FAIL p_only_data: got %h, want abcde", p_rdata);
        end
    endtask

    task automatic test_n_only();
        logic [9:0] na [2];
        logic [14:0] ra [2];
        na[0] = 10'h005; ra[0] = 15'h4005;
        na[1] = 10'h3FF; ra[1] = 15'h43FF;
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, '0, 1'b1, na[i]);
            vectors++;
            if ({p_gnt, n_gnt, ram_re, ram_raddr} !== {1'b0, 1'b1, 1'b1, ra[i]}) begin
                miscompares++;
                $display("FAIL n_only_grant[%0d]: got gp=%b gn=%b re=%b raddr=%h, want 0 1 1 %h",
                         i, p_gnt, n_gnt, ram_re, ram_raddr, ra[i]);
            end
            advance();
            idle(RD_LAT + 1);
            vectors++;
            if (n_rdata !== ram_f(ra[i])) begin
                miscompares++;
                $display("FAIL n_only_data[%0d]: got %h, want %h", i, n_rdata, ram_f(ra[i]));
            end
        end
    endtask

    task automatic test_contention();
        int n_wins = 0;
        for (int i = 0; i < 2 * MAX_WAIT; i++) begin
            drive(1'b1, 14'(i), 1'b1, 10'(i));
            vectors++;
            if ({p_gnt, n_gnt} !== {~e_n, e_n} || e_n !== ((i % MAX_WAIT) == MAX_WAIT - 1)) begin
                miscompares++;
                $display("FAIL contention_grant[%0d]: got gp=%b gn=%b, want gn=%b", i, p_gnt, n_gnt,
                         (i % MAX_WAIT) == MAX_WAIT - 1);
            end
            vectors++;
            if (n_starved !== e_starved) begin
                miscompares++;
                $display("FAIL starved_flag[%0d]: got %b, want %b", i, n_starved, e_starved);
            end
            if (n_gnt) n_wins++;
            advance();
        end
        idle(RD_LAT + 2);
        vectors++;
        if (n_wins !== 2 || n_starved !== 1'b1) begin
            miscompares++;
            $display("FAIL contention_summary: got n_wins=%0d starved=%b, want 2 1", n_wins, n_starved);
        end
    endtask

    task automatic test_wait_reset();
        // Dropping n_req clears the count, so N needs a full run of refusals again.
        int n_at = -1;
        for (int i = 0; i < 3; i++) begin drive(1'b1, 14'h0010, 1'b1, 10'h010); advance(); end
        drive(1'b1, 14'h0011, 1'b0, 10'h000);
        advance();
        for (int i = 0; i < MAX_WAIT; i++) begin
            drive(1'b1, 14'(i + 32), 1'b1, 10'(i + 32));
            if (n_gnt && n_at < 0) n_at = i;
            advance();
        end
        idle(RD_LAT + 2);
        vectors++;
        if (n_at !== MAX_WAIT - 1) begin
            miscompares++;
            $display("FAIL wait_clear: got first N grant at %0d, want %0d", n_at, MAX_WAIT - 1);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0]  pn;
        logic [13:0] pa [4];
        logic [9:0]  na [4];
        pn = 4'b0010;
        pa[0] = 14'h0100; pa[1] = 14'h0000; pa[2] = 14'h0200; pa[3] = 14'h0300;
        na[0] = 10'h000;  na[1] = 10'h010;  na[2] = 10'h000;  na[3] = 10'h000;
        for (int i = 0; i < 4; i++) begin
            drive(~pn[i], pa[i], pn[i], na[i]);
            vectors++;
            if ({p_gnt, n_gnt, ram_re} !== {~pn[i], pn[i], 1'b1} || ram_raddr !== e_addr) begin
                miscompares++;
                $display("FAIL b2b_grant[%0d]: got gp=%b gn=%b re=%b raddr=%h, want %b %b 1 %h",
                         i, p_gnt, n_gnt, ram_re, ram_raddr, ~pn[i], pn[i], e_addr);
            end
            advance();
        end
        idle(RD_LAT + 2);
        vectors++;
        if (sb.size() !== 0) begin
            miscompares++;
            $display("FAIL b2b_drain: got %0d reads outstanding, want 0", sb.size());
        end
    endtask

    task automatic test_reset_inflight();
        drive(1'b1, 14'h0AAA, 1'b0, '0); advance();
        drive(1'b0, '0, 1'b1, 10'h02A);  advance();
        rst = 1'b1; p_req = 1'b1; n_req = 1'b1;
        sb.delete();
        @(negedge sys_clk);
        vectors++;
        if ({p_gnt, n_gnt, ram_re} !== 3'b000) begin
            miscompares++;
            $display("FAIL rst_inflight_gnt: got gp=%b gn=%b re=%b, want 0 0 0", p_gnt, n_gnt, ram_re);
        end
        @(posedge sys_clk);
        @(negedge sys_clk);
        vectors++;
        if ({p_rvalid, n_rvalid, n_starved} !== 3'b000) begin
            miscompares++;
            $display("FAIL rst_inflight_flags: got pv=%b nv=%b st=%b, want 0 0 0", p_rvalid, n_rvalid, n_starved);
        end
        @(posedge sys_clk);
        #1;
        rst = 1'b0;
        model_reset();
        idle(RD_LAT + 3);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_p_only();
        test_n_only();
        test_contention();
        test_wait_reset();
        test_back_to_back();
        test_reset_inflight();
        vectors++;
        if (sb.size() !== 0) begin
            miscompares++;
            $display("FAIL final_drain: got %0d reads outstanding, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
